// File: rtl/stream_if.sv
// stream_if: byte stream valid/ready handshake between the stream FIFO and its consumer.
interface stream_if;
    logic       itvalid;
    logic       itready;
    logic [7:0] itdata;
    modport master (output itvalid, output itdata, input itready);
    modport slave  (input itvalid, input itdata, output itready);
endinterface

// File: rtl/stream_uart_tx.sv
// stream_uart_tx: paces a valid/ready byte stream onto an 8N1/8N2 UART line.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1/8E2).
module stream_uart_tx #(
    parameter int CLK_DIV   = 434,
    parameter int STOP_BITS = 1
) (
    input  logic     clk,
    input  logic     rstn,
    stream_if.slave  s,
    output logic     tx,
    output logic     busy
);
    localparam int DW = $clog2(CLK_DIV);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            tx_q, tx_d;
    logic            wrap;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif
    assign wrap      = div_q == DW'(CLK_DIV - 1);
    assign s.itready = rstn & (state_q == IDLE);
    assign busy      = state_q != IDLE;
    assign tx        = tx_q;
    always_comb begin
        state_d = state_q;
        div_d   = wrap ? '0 : div_q + DW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                div_d = '0;
                tx_d  = 1'b1;
                if (s.itvalid) begin
                    state_d = START;
                    sh_d    = s.itdata;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^s.itdata;
`endif
                end
            end
            START: if (wrap) begin
                state_d = DATA;
                bit_d   = '0;
                tx_d    = sh_q[0];
            end
            DATA: if (wrap) begin
                if (bit_q == 3'd7) begin
                    bit_d = '0;
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
                    tx_d    = par_q;
`else
                    state_d = STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    bit_d = bit_q + 3'd1;
                    sh_d  = sh_q >> 1;
                    tx_d  = sh_q[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (wrap) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (wrap) begin
                    // bit_q counts stop bits here so two stop bits need no extra counter
                    bit_d   = (bit_q == 3'(STOP_BITS - 1)) ? '0 : bit_q + 3'd1;
                    state_d = (bit_q == 3'(STOP_BITS - 1)) ? IDLE : STOP;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: doc/stream_uart_tx.md
# stream_uart_tx

Byte-stream UART transmitter that sits directly downstream of the synchronous stream FIFO, draining its valid/ready byte output and serialising each byte onto an 8N1 (or 8E1) UART line. Carries NFC reader results to the host PC. Owns all bit timing, so the upstream FIFO absorbs bursts while this block paces output at the line rate.

## Interface

- CLK_DIV, default 434: clk cycles per UART bit (434 gives 115200 baud at 50 MHz); legal range ≥ 2.
- STOP_BITS, default 1: number of stop bits, 1 or 2.

- clk  input  1  clock; all logic on the rising edge.
- rstn  input  1  reset, synchronous, active-low.
- itvalid  input  1  upstream byte valid (driven by the FIFO's otvalid).
- itready  output  1  ready to accept a byte (drives the FIFO's otready).
- itdata  input  8  byte to send; sampled only on the handshake.
- tx  output  1  UART serial line, idle high; registered.
- busy  output  1  high while a frame is in progress (state ≠ IDLE).

## Operation

- Handshake: a byte transfers on any edge where itvalid & itready. itready = rstn & (state == IDLE), so it is combinational from registered state only, with no path from itvalid.
- FSM states: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
  - IDLE → START on handshake. The same edge latches itdata into the shift register and drives tx ← 0.
  - START → DATA after CLK_DIV cycles.
  - DATA shifts LSB first: bit i is driven for CLK_DIV cycles, i = 0..7. A 3-bit counter is used.
  - DATA → PARITY or STOP after bit 7.
  - PARITY → STOP after CLK_DIV cycles.
  - STOP drives tx = 1 for STOP_BITS × CLK_DIV cycles, then → IDLE.
- Divider: counter of width $clog2(CLK_DIV) counts 0..CLK_DIV-1. It clears on every state or bit change; each bit lasts exactly CLK_DIV cycles.
- tx in IDLE is 1. itvalid while busy is ignored; the byte stays upstream and is never lost or duplicated.
- Reset values:
  - state = IDLE
  - tx = 1
  - busy = 0
  - itready = 0 while rstn is low
  - divider, bit counter and shift register = 0
- Reset mid-frame: the frame is aborted and the byte is dropped. tx = 1 from the first edge with rstn low.

## Timing

- Latency: tx falls in the first cycle after the handshake edge.
- Frame length from the falling edge of tx: (1 + 8 + P + STOP_BITS) × CLK_DIV cycles, where P = 1 with parity, otherwise 0.
- Back-to-back: with itvalid held high, consecutive handshakes are exactly (9 + P + STOP_BITS) × CLK_DIV + 1 cycles apart. The extra cycle is the single IDLE cycle, where tx = 1 and lengthens the stop bit.
- busy rises on the handshake edge and falls on the edge entering IDLE. It is the exact complement of itready while rstn is high.
- tx is a flop output: no glitches and no combinational path from any input.

## Configuration

- UART_TX_PARITY_EN defined: PARITY state is compiled in. One even-parity bit (XOR of the 8 data bits) is inserted between bit 7 and the stop bit(s). Frame is 8E1 or 8E2.
- UART_TX_PARITY_EN undefined: no PARITY state and no parity logic. Frame is 8N1 or 8N2.

## Test plan

- Reset: hold rstn = 0 for 5 cycles with itvalid = 1 → tx = 1, busy = 0, itready = 0 throughout, and no handshake occurs.
- Single byte (CLK_DIV = 4, STOP_BITS = 1, no parity): send 0x55 → after the handshake tx reads 0, then 1,0,1,0,1,0,1,0, then 1. Each level lasts 4 cycles, 40 cycles total; itready returns on cycle 41.
- Back-to-back (CLK_DIV = 4): FIFO preloaded with 0xA5, 0x3C, 0xFF → handshakes exactly 41 cycles apart. Decoded bytes are 0xA5, 0x3C, 0xFF in order, with none lost or repeated.
- Backpressure: itvalid held high with itdata changing every cycle during a frame → itready stays 0. Only the value present at the next handshake edge is transmitted.
- Mid-frame reset: assert rstn = 0 during data bit 3 of 0x00 → tx = 1 on the next edge and the FSM is in IDLE. After reset release, the next byte transmits with a correct frame.
- Parity (UART_TX_PARITY_EN, CLK_DIV = 4): send 0x07 → parity bit = 1. Send 0x03 → parity bit = 0. Frame is 44 cycles long.
